// File: rtl/lcd_ctrl_param_pkg.sv
// ============================================================================
// Module      : lcd_ctrl_pkg
// Description : Shared command/state encodings and width helpers for the
//               parametrised LCD image-buffer controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package lcd_ctrl_pkg;

    typedef enum logic [3:0] {
        CMD_WRITE  = 4'd0,
        CMD_UP     = 4'd1,
        CMD_DOWN   = 4'd2,
        CMD_LEFT   = 4'd3,
        CMD_RIGHT  = 4'd4,
        CMD_AVG    = 4'd5,
        CMD_MX     = 4'd6,
        CMD_MY     = 4'd7,
        CMD_MAX    = 4'd8,
        CMD_MIN    = 4'd9,
        CMD_ROTCW  = 4'd10,
        CMD_ROTCCW = 4'd11,
        CMD_NOP    = 4'd12
    } cmd_e;

    typedef enum logic [2:0] {
        ST_LOAD  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    function automatic int addr_width(input int w, input int h);
        return $clog2(w * h);
    endfunction

    function automatic int coord_width(input int n);
        return $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_ctrl_param_if.sv
// ============================================================================
// Module      : lcd_ctrl_param_if
// Description : ROM read, IRB write and host command bundle of the controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface lcd_ctrl_param_if #(
    parameter int DW = 8,
    parameter int AW = 6
);
    logic [DW-1:0] IROM_Q;
    logic [3:0]    cmd;
    logic          cmd_valid;
    logic          IROM_EN;
    logic [AW-1:0] IROM_A;
    logic          IRB_RW;
    logic [DW-1:0] IRB_D;
    logic [AW-1:0] IRB_A;
    logic          busy;
    logic          done;

    modport master (
        output IROM_Q, cmd, cmd_valid,
        input  IROM_EN, IROM_A, IRB_RW, IRB_D, IRB_A, busy, done
    );

    modport slave (
        input  IROM_Q, cmd, cmd_valid,
        output IROM_EN, IROM_A, IRB_RW, IRB_D, IRB_A, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/lcd_ctrl_param_win_alu.sv
// ============================================================================
// Module      : lcd_win_alu
// Description : Combinational 2x2 window operator (AVG/MAX/MIN/mirror/rotate).
//               Rotation only exists when LCD_CTRL_ROT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module lcd_win_alu
    import lcd_ctrl_pkg::*;
#(
    parameter int DW = 8
) (
    input  wire logic [DW-1:0] a,
    input  wire logic [DW-1:0] b,
    input  wire logic [DW-1:0] c,
    input  wire logic [DW-1:0] d,
    input  wire cmd_e          cmd,
    output logic      [DW-1:0] new_a,
    output logic      [DW-1:0] new_b,
    output logic      [DW-1:0] new_c,
    output logic      [DW-1:0] new_d,
    output logic               we
);

    logic [DW+1:0] w_sum;
    logic [DW-1:0] w_max_ab, w_max_cd, w_max;
    logic [DW-1:0] w_min_ab, w_min_cd, w_min;

    assign w_sum    = (DW+2)'(a) + (DW+2)'(b) + (DW+2)'(c) + (DW+2)'(d);
    assign w_max_ab = (a > b) ? a : b;
    assign w_max_cd = (c > d) ? c : d;
    assign w_max    = (w_max_ab > w_max_cd) ? w_max_ab : w_max_cd;
    assign w_min_ab = (a < b) ? a : b;
    assign w_min_cd = (c < d) ? c : d;
    assign w_min    = (w_min_ab < w_min_cd) ? w_min_ab : w_min_cd;

    always_comb begin
        new_a = a;
        new_b = b;
        new_c = c;
        new_d = d;
        we    = 1'b0;
        case (cmd)
            CMD_AVG: begin
                new_a = w_sum[DW+1:2];
                new_b = w_sum[DW+1:2];
                new_c = w_sum[DW+1:2];
                new_d = w_sum[DW+1:2];
                we    = 1'b1;
            end
            CMD_MX: begin
                new_a = c;
                new_b = d;
                new_c = a;
                new_d = b;
                we    = 1'b1;
            end
            CMD_MY: begin
                new_a = b;
                new_b = a;
                new_c = d;
                new_d = c;
                we    = 1'b1;
            end
            CMD_MAX: begin
                new_a = w_max;
                new_b = w_max;
                new_c = w_max;
                new_d = w_max;
                we    = 1'b1;
            end
            CMD_MIN: begin
                new_a = w_min;
                new_b = w_min;
                new_c = w_min;
                new_d = w_min;
                we    = 1'b1;
            end
`ifdef LCD_CTRL_ROT_EN
            CMD_ROTCW: begin
                new_a = c;
                new_b = a;
                new_c = d;
                new_d = b;
                we    = 1'b1;
            end
            CMD_ROTCCW: begin
                new_a = b;
                new_b = d;
                new_c = a;
                new_d = c;
                we    = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/lcd_ctrl_param.sv
// ============================================================================
// Module      : lcd_ctrl_param
// Description : Parametrised image-buffer controller: IROM load, 2x2 window
//               ops, IRB write-back. Rotation gated by LCD_CTRL_ROT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module lcd_ctrl_param
    import lcd_ctrl_pkg::*;
#(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int DW    = 8
) (
    input  wire logic       clk,
    input  wire logic       reset,
    lcd_ctrl_param_if.slave bus
);

    localparam int c_N  = IMG_W * IMG_H;
    localparam int c_AW = addr_width(IMG_W, IMG_H);
    localparam int c_XW = coord_width(IMG_W);
    localparam int c_YW = coord_width(IMG_H);

    localparam logic [c_AW:0]   c_CNT_LOAD_END = (c_AW+1)'(c_N);
    localparam logic [c_AW:0]   c_CNT_WR_END   = (c_AW+1)'(c_N - 1);
    localparam logic [c_XW-1:0] c_X_MAX        = c_XW'(IMG_W - 2);
    localparam logic [c_YW-1:0] c_Y_MAX        = c_YW'(IMG_H - 2);
    localparam logic [c_XW-1:0] c_X_INIT       = c_XW'(IMG_W / 2 - 1);
    localparam logic [c_YW-1:0] c_Y_INIT       = c_YW'(IMG_H / 2 - 1);

    typedef struct packed {
        logic [c_YW-1:0] y;
        logic [c_XW-1:0] x;
    } coord_t;

    state_e          r_state, w_state_nxt;
    logic [c_AW:0]   r_cnt;
    coord_t          r_pt;
    cmd_e            r_cmd;
    logic [DW-1:0]   r_cache [c_N];

    logic            w_accept;
    logic [c_XW-1:0] w_x1;
    logic [c_YW-1:0] w_y1;
    logic [c_AW-1:0] w_cnt_a, w_load_a;
    logic [c_AW-1:0] w_ia, w_ib, w_ic, w_id;
    logic [DW-1:0]   w_na, w_nb, w_nc, w_nd;
    logic            w_alu_we;

    assign w_accept = (r_state == ST_IDLE) && bus.cmd_valid;
    assign w_cnt_a  = r_cnt[c_AW-1:0];
    assign w_load_a = w_cnt_a - c_AW'(1);
    assign w_x1     = r_pt.x + c_XW'(1);
    assign w_y1     = r_pt.y + c_YW'(1);

    // Power-of-two geometry makes row-major y*IMG_W+x a plain concatenation
    assign w_ia = {r_pt.y, r_pt.x};
    assign w_ib = {r_pt.y, w_x1};
    assign w_ic = {w_y1, r_pt.x};
    assign w_id = {w_y1, w_x1};

    lcd_win_alu #(.DW(DW)) u_alu (
        .a     (r_cache[w_ia]),
        .b     (r_cache[w_ib]),
        .c     (r_cache[w_ic]),
        .d     (r_cache[w_id]),
        .cmd   (r_cmd),
        .new_a (w_na),
        .new_b (w_nb),
        .new_c (w_nc),
        .new_d (w_nd),
        .we    (w_alu_we)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_LOAD;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        bus.IROM_EN = 1'b0;
        bus.IROM_A  = '0;
        bus.IRB_RW  = 1'b1;
        bus.IRB_A   = '0;
        bus.IRB_D   = '0;
        bus.busy    = 1'b1;
        bus.done    = 1'b0;
        case (r_state)
            ST_LOAD: begin
                // State sits in LOAD while reset is held; keep the ROM quiet then
                bus.IROM_EN = reset && (r_cnt != c_CNT_LOAD_END);
                bus.IROM_A  = w_cnt_a;
                if (r_cnt == c_CNT_LOAD_END) w_state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                bus.busy = 1'b0;
                if (bus.cmd_valid)
                    w_state_nxt = (cmd_e'(bus.cmd) == CMD_WRITE) ? ST_WRITE : ST_EXEC;
            end
            ST_EXEC: w_state_nxt = ST_IDLE;
            ST_WRITE: begin
                bus.IRB_RW = 1'b0;
                bus.IRB_A  = w_cnt_a;
                bus.IRB_D  = r_cache[w_cnt_a];
                if (r_cnt == c_CNT_WR_END) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                bus.done    = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else begin
            case (r_state)
                ST_LOAD:  r_cnt <= (r_cnt == c_CNT_LOAD_END) ? '0 : r_cnt + (c_AW+1)'(1);
                ST_WRITE: r_cnt <= (r_cnt == c_CNT_WR_END)   ? '0 : r_cnt + (c_AW+1)'(1);
                default:  r_cnt <= '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cmd  <= CMD_NOP;
            r_pt.x <= c_X_INIT;
            r_pt.y <= c_Y_INIT;
        end else begin
            if (w_accept) r_cmd <= cmd_e'(bus.cmd);
            if (r_state == ST_EXEC) begin
                case (r_cmd)
                    CMD_UP:    if (r_pt.y != '0)      r_pt.y <= r_pt.y - c_YW'(1);
                    CMD_DOWN:  if (r_pt.y != c_Y_MAX) r_pt.y <= w_y1;
                    CMD_LEFT:  if (r_pt.x != '0)      r_pt.x <= r_pt.x - c_XW'(1);
                    CMD_RIGHT: if (r_pt.x != c_X_MAX) r_pt.x <= w_x1;
                    default: ;
                endcase
            end
        end
    end

    // Cache survives reset; LOAD with r_cnt==0 (incl. while reset is held) writes nothing
    always_ff @(posedge clk) begin
        if (r_state == ST_LOAD && r_cnt != '0) begin
            r_cache[w_load_a] <= bus.IROM_Q;
        end else if (r_state == ST_EXEC && w_alu_we) begin
            r_cache[w_ia] <= w_na;
            r_cache[w_ib] <= w_nb;
            r_cache[w_ic] <= w_nc;
            r_cache[w_id] <= w_nd;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lcd_ctrl_param.sv
// ============================================================================
// Module      : tb_lcd_ctrl_param
// Description : Directed vector bench for lcd_ctrl_param (8x8, DW=8); rotation
//               expectations follow LCD_CTRL_ROT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_lcd_ctrl_param;
    import lcd_ctrl_pkg::*;

    localparam int c_W  = 8;
    localparam int c_H  = 8;
    localparam int c_DW = 8;
    localparam int c_AW = 6;
    localparam int c_N  = 64;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    lcd_ctrl_param_if #(.DW(c_DW), .AW(c_AW)) bus ();

    lcd_ctrl_param #(.IMG_W(c_W), .IMG_H(c_H), .DW(c_DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] rom  [c_N];
    logic [7:0] mdl  [c_N];
    logic [7:0] dump [c_N];
    int n_cmp = 0;
    int n_err = 0;

    always @(posedge clk) if (bus.IROM_EN) bus.IROM_Q <= rom[bus.IROM_A];

    typedef struct {
        logic [3:0] cmd;
        bit         poke;
        bit         chk;
        int         i0, i1, i2, i3;
        int         e0, e1, e2, e3;
    } vec_t;
    vec_t vq[$];

    function automatic vec_t mv(input logic [3:0] c);
        vec_t v;
        v.cmd = c; v.poke = 1'b0; v.chk = 1'b0;
        v.i0 = 0; v.i1 = 0; v.i2 = 0; v.i3 = 0;
        v.e0 = 0; v.e1 = 0; v.e2 = 0; v.e3 = 0;
        return v;
    endfunction

    function automatic vec_t ck(input logic [3:0] c, input int i0, input int i1, input int i2,
                                input int i3, input int e0, input int e1, input int e2,
                                input int e3, input bit poke);
        vec_t v;
        v.cmd = c; v.poke = poke; v.chk = 1'b1;
        v.i0 = i0; v.i1 = i1; v.i2 = i2; v.i3 = i3;
        v.e0 = e0; v.e1 = e1; v.e2 = e2; v.e3 = e3;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"},    int'(bus.busy),    1);
        chk({tag, "_done"},    int'(bus.done),    0);
        chk({tag, "_irom_en"}, int'(bus.IROM_EN), 0);
        chk({tag, "_irom_a"},  int'(bus.IROM_A),  0);
        chk({tag, "_irb_rw"},  int'(bus.IRB_RW),  1);
        chk({tag, "_irb_a"},   int'(bus.IRB_A),   0);
        chk({tag, "_irb_d"},   int'(bus.IRB_D),   0);
    endtask

    // Releases reset and follows the load: address sweep, busy fall cycle, no done
    task automatic load_check(input string tag);
        int k = 0, bad = 0, dn = 0, cyc = 0;
        reset = 1'b1;
        #1;
        while (cyc < 200) begin
            if (bus.IROM_EN) begin
                if (int'(bus.IROM_A) != k) bad++;
                k++;
            end
            if (bus.done) dn++;
            tick();
            cyc++;
            if (!bus.busy) break;
        end
        chk({tag, "_busy_fall_cycle"}, cyc, c_N + 1);
        chk({tag, "_irom_addr_count"}, k, c_N);
        chk({tag, "_irom_addr_order"}, bad, 0);
        chk({tag, "_no_done"}, dn, 0);
    endtask

    task automatic wait_idle(input string tag);
        int g = 0;
        while (bus.busy && g < 300) begin
            tick();
            g++;
        end
        if (g >= 300) chk({tag, "_idle_timeout"}, int'(bus.busy), 0);
    endtask

    task automatic issue(input logic [3:0] c, input bit poke, output int bcyc);
        wait_idle("issue");
        bus.cmd = c;
        bus.cmd_valid = 1'b1;
        tick();
        if (poke) bus.cmd = 4'd2;
        else      bus.cmd_valid = 1'b0;
        bcyc = 0;
        while (bus.busy && bcyc < 300) begin
            tick();
            bcyc++;
            bus.cmd_valid = 1'b0;
        end
    endtask

    task automatic dump_image(input string tag);
        int nw = 0, bad = 0, dn = 0;
        bit seen_done = 1'b0;
        wait_idle(tag);
        bus.cmd = 4'd0;
        bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (!bus.IRB_RW) begin
                if (int'(bus.IRB_A) != nw || seen_done) bad++;
                dump[bus.IRB_A] = bus.IRB_D;
                nw++;
            end else if (nw > 0 && nw < c_N) begin
                bad++;
            end
            if (bus.done) begin
                dn++;
                seen_done = 1'b1;
                if (nw != c_N || !bus.busy) bad++;
            end
            if (seen_done && !bus.busy) break;
            tick();
        end
        chk({tag, "_write_count"}, nw, c_N);
        chk({tag, "_write_seq"}, bad, 0);
        chk({tag, "_done_pulses"}, dn, 1);
    endtask

    task automatic cmp_image(input string tag);
        for (int i = 0; i < c_N; i++)
            chk($sformatf("%s_px%0d", tag, i), int'(dump[i]), int'(mdl[i]));
    endtask

    task automatic run_vecs(input string tag);
        int bc;
        for (int k = 0; k < vq.size(); k++) begin
            issue(vq[k].cmd, vq[k].poke, bc);
            chk($sformatf("%s_v%0d_busy_cycles", tag, k), bc, 1);
            if (vq[k].chk) begin
                mdl[vq[k].i0] = 8'(vq[k].e0);
                mdl[vq[k].i1] = 8'(vq[k].e1);
                mdl[vq[k].i2] = 8'(vq[k].e2);
                mdl[vq[k].i3] = 8'(vq[k].e3);
                dump_image($sformatf("%s_v%0d", tag, k));
                chk($sformatf("%s_v%0d_a", tag, k), int'(dump[vq[k].i0]), vq[k].e0);
                chk($sformatf("%s_v%0d_b", tag, k), int'(dump[vq[k].i1]), vq[k].e1);
                chk($sformatf("%s_v%0d_c", tag, k), int'(dump[vq[k].i2]), vq[k].e2);
                chk($sformatf("%s_v%0d_d", tag, k), int'(dump[vq[k].i3]), vq[k].e3);
            end
        end
    endtask

    initial begin
        int g;
        bus.cmd = 4'd0;
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < c_N; i++) begin
            rom[i] = 8'(i);
            mdl[i] = 8'(i);
        end
        #2 reset = 1'b0;
        repeat (3) tick();
        chk_reset_vals("por");

        // Identity image: load timing, full dump, then window ops from (3,3)
        load_check("loadA");
        dump_image("wrA");
        cmp_image("imgA");

        vq.push_back(ck(4'd5, 27, 28, 35, 36, 31, 31, 31, 31, 1'b0));
        for (int i = 0; i < 10; i++) vq.push_back(mv(4'd1));
        for (int i = 0; i < 10; i++) vq.push_back(mv(4'd3));
        vq.push_back(ck(4'd6, 0, 1, 8, 9, 8, 9, 0, 1, 1'b0));
        vq.push_back(ck(4'd7, 0, 1, 8, 9, 9, 8, 1, 0, 1'b0));
        run_vecs("A");
        cmp_image("imgA2");

        // Patched image, load aborted by reset at address 20
        rom[0]  = 8'd5;   rom[1]  = 8'd200; rom[8]  = 8'd7; rom[9]  = 8'd9;
        rom[36] = 8'd3;   rom[37] = 8'd4;   rom[44] = 8'd2; rom[45] = 8'd9;
        rom[54] = 8'd1;   rom[55] = 8'd2;   rom[62] = 8'd3; rom[63] = 8'd4;
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        g = 0;
        while (!(bus.IROM_EN && int'(bus.IROM_A) == 20) && g < 200) begin
            tick();
            g++;
        end
        chk("abort_load_reached_a20", int'(bus.IROM_A), 20);
        #1 reset = 1'b0;
        #1 chk_reset_vals("rst_load");
        tick();
        tick();
        load_check("loadB");
        for (int i = 0; i < c_N; i++) mdl[i] = rom[i];

        vq.delete();
        for (int i = 0; i < 3; i++) vq.push_back(mv(4'd1));
        for (int i = 0; i < 3; i++) vq.push_back(mv(4'd3));
        vq.push_back(ck(4'd8, 0, 1, 8, 9, 200, 200, 200, 200, 1'b1));
        for (int i = 0; i < 4; i++) vq.push_back(mv(4'd4));
        for (int i = 0; i < 4; i++) vq.push_back(mv(4'd2));
        vq.push_back(ck(4'd9, 36, 37, 44, 45, 2, 2, 2, 2, 1'b0));
        for (int i = 0; i < 3; i++) vq.push_back(mv(4'd4));
        for (int i = 0; i < 3; i++) vq.push_back(mv(4'd2));
`ifdef LCD_CTRL_ROT_EN
        vq.push_back(ck(4'd10, 54, 55, 62, 63, 3, 1, 4, 2, 1'b0));
`else
        vq.push_back(ck(4'd10, 54, 55, 62, 63, 1, 2, 3, 4, 1'b0));
`endif
        vq.push_back(ck(4'd11, 54, 55, 62, 63, 1, 2, 3, 4, 1'b0));
        vq.push_back(ck(4'd12, 54, 55, 62, 63, 1, 2, 3, 4, 1'b0));
        vq.push_back(ck(4'd15, 54, 55, 62, 63, 1, 2, 3, 4, 1'b0));
        vq.push_back(ck(4'd5, 54, 55, 62, 63, 2, 2, 2, 2, 1'b0));
        run_vecs("B");
        cmp_image("imgB");

        // WRITE aborted by reset at address 30, then a clean reload and dump
        wait_idle("wrabort");
        bus.cmd = 4'd0;
        bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        g = 0;
        while (!(!bus.IRB_RW && int'(bus.IRB_A) == 30) && g < 200) begin
            tick();
            g++;
        end
        chk("abort_write_reached_a30", int'(bus.IRB_A), 30);
        #1 reset = 1'b0;
        #1 chk_reset_vals("rst_wr");
        tick();
        tick();
        load_check("loadC");
        for (int i = 0; i < c_N; i++) mdl[i] = rom[i];
        dump_image("wrC");
        cmp_image("imgC");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
